// File: rtl/md5_search_scheduler.sv
// md5_search_scheduler
// Hands out starting characters CHAR_FIRST..CHAR_LAST to N_LANES MD5 cracker
// lanes in round-robin order, stops all lanes on the first match and reports
// either the recovered plaintext or exhaustion of the search space.
//
// Lane handshake: lane_go[i] is a one-cycle pulse that hands lane i the
// character on lane_start_pos[i]. The lane answers with exactly one one-cycle
// pulse, either lane_done[i] (subspace exhausted) or lane_match[i] (with
// lane_plaintext[i] valid in that cycle). Answers from lanes that hold no
// work are ignored. lane_abort is a one-cycle broadcast that cancels all
// outstanding work.
module md5_search_scheduler #(
    parameter int         N_LANES    = 4,
    parameter logic [7:0] CHAR_FIRST = 8'h61,
    parameter logic [7:0] CHAR_LAST  = 8'h7A
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [127:0]               target_hash,
    output logic [N_LANES-1:0]         lane_go,
    output logic [8*N_LANES-1:0]       lane_start_pos,
    output logic [127:0]               lane_target,
    output logic                       lane_abort,
    input  logic [N_LANES-1:0]         lane_done,
    input  logic [N_LANES-1:0]         lane_match,
    input  logic [128*N_LANES-1:0]     lane_plaintext,
    output logic                       busy,
    output logic                       found,
    output logic                       exhausted,
    output logic [127:0]               result_plaintext,
    output logic [$clog2(N_LANES)-1:0] result_lane,
    output logic [1:0]                 fsm_state
);

    localparam int LW = $clog2(N_LANES);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_DRAIN    = 2'd2
    } state_t;

    state_t               state, state_n;

    // next_char is one bit wider than a character so that CHAR_LAST = 8'hFF
    // does not wrap back to 0 after being issued.
    logic [8:0]           next_char, next_char_n;
    logic [LW-1:0]        rr_ptr, rr_ptr_n;
    logic [N_LANES-1:0]   lane_busy, lane_busy_n;

    logic [N_LANES-1:0]   lane_go_n;
    logic [8*N_LANES-1:0] lane_start_pos_n;
    logic [127:0]         lane_target_n;
    logic                 lane_abort_n;
    logic                 busy_n;
    logic                 found_n;
    logic                 exhausted_n;
    logic [127:0]         result_plaintext_n;
    logic [LW-1:0]        result_lane_n;

    logic [N_LANES-1:0]   match_hits;
    logic                 match_any;
    logic [LW-1:0]        match_idx;

    logic                 sel_any;
    logic [LW-1:0]        sel_idx;
    int                   rot;
    logic [LW-1:0]        rot_idx;

    assign fsm_state = state;

    // Lowest-index lane reporting a match while it actually holds work.
    always_comb begin
        match_hits = lane_match & lane_busy;
        match_any  = |match_hits;
        match_idx  = '0;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (match_hits[i]) begin
                match_idx = LW'(i);
            end
        end
    end

    // First idle lane at or after rr_ptr, wrapping modulo N_LANES. The scan
    // runs from the far end back so the closest candidate is assigned last.
    // Only the registered busy mask is used, so a lane reporting done this
    // cycle is not re-dispatched until the next one.
    always_comb begin
        sel_any = 1'b0;
        sel_idx = '0;
        rot     = 0;
        rot_idx = '0;
        for (int k = N_LANES - 1; k >= 0; k--) begin
            rot     = (int'(rr_ptr) + k) % N_LANES;
            rot_idx = LW'(rot);
            if (!lane_busy[rot_idx]) begin
                sel_any = 1'b1;
                sel_idx = rot_idx;
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n            = state;
        next_char_n        = next_char;
        rr_ptr_n           = rr_ptr;
        lane_busy_n        = lane_busy;
        lane_go_n          = '0;
        lane_start_pos_n   = lane_start_pos;
        lane_target_n      = lane_target;
        lane_abort_n       = 1'b0;
        busy_n             = busy;
        found_n            = found;
        exhausted_n        = exhausted;
        result_plaintext_n = result_plaintext;
        result_lane_n      = result_lane;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    lane_target_n      = target_hash;
                    next_char_n        = {1'b0, CHAR_FIRST};
                    found_n            = 1'b0;
                    exhausted_n        = 1'b0;
                    result_plaintext_n = '0;
                    result_lane_n      = '0;
                    lane_busy_n        = '0;
                    busy_n             = 1'b1;
                    state_n            = ST_DISPATCH;
                end
            end

            ST_DISPATCH, ST_DRAIN: begin
                lane_busy_n = lane_busy & ~lane_done;
                if (match_any) begin
                    // A match pre-empts any dispatch in the same cycle.
                    result_plaintext_n = lane_plaintext[int'(match_idx)*128 +: 128];
                    result_lane_n      = match_idx;
                    found_n            = 1'b1;
                    busy_n             = 1'b0;
                    lane_abort_n       = 1'b1;
                    lane_busy_n        = '0;
                    state_n            = ST_IDLE;
                end else if (state == ST_DISPATCH) begin
                    if (sel_any) begin
                        lane_go_n[sel_idx]                       = 1'b1;
                        lane_start_pos_n[int'(sel_idx)*8 +: 8]   = next_char[7:0];
                        lane_busy_n[sel_idx]                     = 1'b1;
                        next_char_n                              = next_char + 9'd1;
                        rr_ptr_n = (int'(sel_idx) == N_LANES - 1) ? '0 : sel_idx + 1'b1;
                        if (next_char == {1'b0, CHAR_LAST}) begin
                            state_n = ST_DRAIN;
                        end
                    end
                end else begin
                    // Draining: finish as soon as the last outstanding lane
                    // reports, so exhausted appears the cycle after its done.
                    if (lane_busy_n == '0) begin
                        exhausted_n = 1'b1;
                        busy_n      = 1'b0;
                        state_n     = ST_IDLE;
                    end
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything without an abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            next_char        <= '0;
            rr_ptr           <= '0;
            lane_busy        <= '0;
            lane_go          <= '0;
            lane_start_pos   <= '0;
            lane_target      <= '0;
            lane_abort       <= 1'b0;
            busy             <= 1'b0;
            found            <= 1'b0;
            exhausted        <= 1'b0;
            result_plaintext <= '0;
            result_lane      <= '0;
        end else begin
            state            <= state_n;
            next_char        <= next_char_n;
            rr_ptr           <= rr_ptr_n;
            lane_busy        <= lane_busy_n;
            lane_go          <= lane_go_n;
            lane_start_pos   <= lane_start_pos_n;
            lane_target      <= lane_target_n;
            lane_abort       <= lane_abort_n;
            busy             <= busy_n;
            found            <= found_n;
            exhausted        <= exhausted_n;
            result_plaintext <= result_plaintext_n;
            result_lane      <= result_lane_n;
        end
    end

endmodule

// File: tb/tb_md5_search_scheduler.sv
// Self-checking bench for md5_search_scheduler: exhaustion, match, multiple
// matches, round-robin reuse, ignored start/answers and asynchronous reset.
module tb_md5_search_scheduler;

    localparam int          N   = 4;
    localparam logic [7:0]  CF  = 8'h61;
    localparam logic [7:0]  CL  = 8'h7A;
    localparam logic [127:0] HV = 128'h2db1850a4fe292bd2706ffd78dbe44b9;
    localparam logic [127:0] HX = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] VADER = 128'h7661646572;

    logic               clk;
    logic               reset;
    logic               start;
    logic [127:0]       target_hash;
    logic [N-1:0]       lane_go;
    logic [8*N-1:0]     lane_start_pos;
    logic [127:0]       lane_target;
    logic               lane_abort;
    logic [N-1:0]       lane_done;
    logic [N-1:0]       lane_match;
    logic [128*N-1:0]   lane_plaintext;
    logic               busy;
    logic               found;
    logic               exhausted;
    logic [127:0]       result_plaintext;
    logic [1:0]         result_lane;
    logic [1:0]         fsm_state;

    int total;
    int bad;
    int cyc;
    int start_cyc;
    int last_done;
    int go_count;
    int abort_count;
    int done_cnt[N];
    bit auto_done;
    int v_cycle;
    logic [1:0] v_lane;
    int match_cyc;
    bit matched;

    logic [7:0]   exp_q[$];
    logic [7:0]   lane_q[$];
    logic [127:0] res_q[$];
    logic [1:0]   rlane_q[$];

    md5_search_scheduler #(
        .N_LANES   (N),
        .CHAR_FIRST(CF),
        .CHAR_LAST (CL)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .target_hash     (target_hash),
        .lane_go         (lane_go),
        .lane_start_pos  (lane_start_pos),
        .lane_target     (lane_target),
        .lane_abort      (lane_abort),
        .lane_done       (lane_done),
        .lane_match      (lane_match),
        .lane_plaintext  (lane_plaintext),
        .busy            (busy),
        .found           (found),
        .exhausted       (exhausted),
        .result_plaintext(result_plaintext),
        .result_lane     (result_lane),
        .fsm_state       (fsm_state)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // advance to 1 time unit after the next rising edge; inputs default low
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        start      = 1'b0;
        lane_done  = '0;
        lane_match = '0;
    endtask

    task automatic randomize_plaintexts();
        for (int i = 0; i < N; i++) begin
            lane_plaintext[i*128 +: 128] = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},      128'(busy),             128'(0));
        check({tag, "_found"},     128'(found),            128'(0));
        check({tag, "_exhausted"}, 128'(exhausted),        128'(0));
        check({tag, "_go"},        128'(lane_go),          128'(0));
        check({tag, "_abort"},     128'(lane_abort),       128'(0));
        check({tag, "_pos"},       128'(lane_start_pos),   128'(0));
        check({tag, "_target"},    lane_target,            128'(0));
        check({tag, "_res_pt"},    result_plaintext,       128'(0));
        check({tag, "_res_lane"},  128'(result_lane),      128'(0));
        check({tag, "_state"},     128'(fsm_state),        128'(0));
    endtask

    // drive start in the current cycle (cycle 0) and check cycle 1
    task automatic start_search(input logic [127:0] h);
        exp_q.delete();
        for (int c = int'(CF); c <= int'(CL); c++) exp_q.push_back(8'(c));
        go_count    = 0;
        abort_count = 0;
        v_cycle     = -100;
        last_done   = -100;
        for (int i = 0; i < N; i++) done_cnt[i] = 0;
        start       = 1'b1;
        target_hash = h;
        start_cyc   = cyc;
        tick();
        check("c1_busy",      128'(busy),      128'(1));
        check("c1_target",    lane_target,     h);
        check("c1_found",     128'(found),     128'(0));
        check("c1_exhausted", 128'(exhausted), 128'(0));
    endtask

    // lane model: watch lane_go against the expected queue, emit auto dones
    task automatic service();
        if (lane_abort) begin
            abort_count++;
            for (int i = 0; i < N; i++) done_cnt[i] = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (done_cnt[i] > 0) begin
                done_cnt[i]--;
                if (done_cnt[i] == 0) begin
                    lane_done[i] = 1'b1;
                    last_done    = cyc;
                end
            end
        end
        if (lane_go != '0) begin
            check("one_go", 128'($countones(lane_go)), 128'(1));
            if (go_count == 0) check("first_go_cycle", 128'(cyc - start_cyc), 128'(2));
            for (int i = 0; i < N; i++) begin
                if (lane_go[i]) begin
                    go_count++;
                    if (exp_q.size() == 0) begin
                        check("go_unexpected", 128'(lane_go), 128'(0));
                    end else begin
                        check("go_char", 128'(lane_start_pos[i*8 +: 8]), 128'(exp_q.pop_front()));
                    end
                    if (lane_q.size() > 0) check("go_lane", 128'(i), 128'(lane_q.pop_front()));
                    if (auto_done) done_cnt[i] = 3;
                    if (lane_start_pos[i*8 +: 8] == 8'h76) begin
                        v_lane  = 2'(i);
                        v_cycle = cyc;
                    end
                end
            end
        end
    endtask

    task automatic check_result(input string tag);
        check({tag, "_found"},  128'(found),      128'(1));
        check({tag, "_busy"},   128'(busy),       128'(0));
        check({tag, "_abort"},  128'(lane_abort), 128'(1));
        check({tag, "_timing"}, 128'(cyc - match_cyc), 128'(1));
        if (res_q.size() > 0)   check({tag, "_pt"},   result_plaintext,    res_q.pop_front());
        if (rlane_q.size() > 0) check({tag, "_lane"}, 128'(result_lane),  128'(rlane_q.pop_front()));
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; start_cyc = 0; last_done = -100;
        go_count = 0; abort_count = 0; auto_done = 1'b1; v_cycle = -100;
        v_lane = '0; match_cyc = -100; matched = 1'b0;
        for (int i = 0; i < N; i++) done_cnt[i] = 0;
        reset = 1'b1; start = 1'b0; target_hash = '0;
        lane_done = '0; lane_match = '0; lane_plaintext = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst");
        reset = 1'b0;
        tick();

        // exhaustion with a start pulse ignored mid-search
        randomize_plaintexts();
        auto_done = 1'b1;
        start_search(HX);
        for (int k = 0; k < 300 && !exhausted; k++) begin
            tick();
            service();
            if (cyc == start_cyc + 4) begin
                start       = 1'b1;
                target_hash = ~HX;
            end
        end
        check("exh_flag",     128'(exhausted),       128'(1));
        check("exh_timing",   128'(cyc - last_done), 128'(1));
        check("exh_found",    128'(found),           128'(0));
        check("exh_busy",     128'(busy),            128'(0));
        check("exh_go_count", 128'(go_count),        128'(26));
        check("exh_left",     128'(exp_q.size()),    128'(0));
        check("exh_no_abort", 128'(abort_count),     128'(0));
        check("exh_target",   lane_target,           HX);
        repeat (3) begin
            tick();
            service();
        end
        check("exh_held", 128'(exhausted), 128'(1));

        // match on the lane given 'v'
        randomize_plaintexts();
        start_search(HV);
        matched = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            tick();
            service();
            if (!matched && v_cycle >= 0 && cyc == v_cycle + 2) begin
                lane_match[v_lane] = 1'b1;
                lane_plaintext[int'(v_lane)*128 +: 128] = VADER;
                res_q.push_back(VADER);
                rlane_q.push_back(v_lane);
                match_cyc = cyc;
                matched   = 1'b1;
            end
        end
        check_result("m");
        exp_q.delete();
        tick();
        service();
        check("m_abort_drop", 128'(lane_abort), 128'(0));
        repeat (8) begin
            tick();
            service();
        end
        check("m_abort_count", 128'(abort_count), 128'(1));
        check("m_found_held",  128'(found),       128'(1));

        // simultaneous matches on lanes 1 and 3; lane 1 also reports done
        randomize_plaintexts();
        auto_done = 1'b0;
        start_search(HX);
        repeat (5) begin
            tick();
            service();
        end
        lane_match = 4'b1010;
        lane_done  = 4'b0010;
        res_q.push_back(lane_plaintext[128 +: 128]);
        rlane_q.push_back(2'd1);
        match_cyc = cyc;
        tick();
        service();
        check_result("sim");

        // round-robin reuse after reset, plus a match from an idle lane
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        lane_q.delete();
        for (int i = 0; i < N; i++) lane_q.push_back(8'(i));
        start_search(HX);
        tick(); service();
        tick(); service();
        lane_match = 4'b1000;
        tick(); service();
        check("rr_idle_match_found", 128'(found), 128'(0));
        check("rr_idle_match_busy",  128'(busy),  128'(1));
        tick(); service();
        tick(); service();
        lane_done = 4'b0101;
        lane_q.push_back(8'd0);
        lane_q.push_back(8'd2);
        tick(); service();
        check("rr_no_same_cycle", 128'(lane_go), 128'(0));
        tick(); service();
        check("rr_e_lane0", 128'(lane_go), 128'(4'b0001));
        tick(); service();
        check("rr_f_lane2", 128'(lane_go), 128'(4'b0100));
        check("rr_lane_q_empty", 128'(lane_q.size()), 128'(0));

        // asynchronous reset in the middle of dispatch, then a fresh search
        #2;
        reset = 1'b1;
        #1;
        check_zero("arst");
        @(posedge clk);
        #1;
        check("arst_no_abort", 128'(lane_abort), 128'(0));
        reset = 1'b0;
        tick();
        lane_q.delete();
        lane_q.push_back(8'd0);
        start_search(HX);
        tick();
        service();
        check("arst_restart_go",  128'(lane_go),             128'(4'b0001));
        check("arst_restart_pos", 128'(lane_start_pos[7:0]), 128'(CF));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
